// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared constants and helpers for the sequential binary-to-BCD converter
package bin2bcd_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // Largest value representable in the given number of decimal digits
  function automatic int max_dec(input int digits);
    int r;
    r = 1;
    for (int i = 0; i < digits; i++) r = r * 10;
    return r - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - request/result bundle between a requester and the BCD converter
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
) ();

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (output start, bin, input busy, done, bcd, ovf);
  modport slave  (input start, bin, output busy, done, bcd, ovf);

endinterface

// File: rtl/bin2bcd_seq_bcd_add3.sv
// rtl/bin2bcd_seq_bcd_add3.sv - double-dabble digit correction for one BCD nibble
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= ADD3_THRESH) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter; BIN2BCD_OVF_SAT_EN saturates overflowed results to all nines
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic clk,
  input  logic rst_n,
  bin2bcd_seq_if.slave bus
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [31:0] MAX_DEC = 32'(max_dec(DIGITS));

  logic [1:0]         state;
  logic [BIN_W-1:0]   shift_q;
  logic [W-1:0]       scratch_q;
  logic [W-1:0]       corr;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_next;
  logic [W-1:0]       bcd_q;
  logic               ovf_q;
  logic               done_q;
  logic [W-1:0]       result;
  logic [W+BIN_W-1:0] shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch_q[4*g +: 4]),
      .dout (corr[4*g +: 4])
    );
  end

  // Carry out of the top nibble falls off here, giving value mod 10^DIGITS
  assign shifted = {corr, shift_q} << 1;

`ifdef BIN2BCD_OVF_SAT_EN
  assign result = ovf_next ? {DIGITS{4'h9}} : scratch_q;
`else
  assign result = scratch_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt       <= '0;
      ovf_next  <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            shift_q   <= bus.bin;
            scratch_q <= '0;
            cnt       <= '0;
            ovf_next  <= (32'(bus.bin) > MAX_DEC);
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scratch_q <= shifted[W+BIN_W-1:BIN_W];
          shift_q   <= shifted[BIN_W-1:0];
          cnt       <= cnt + 1'b1;
          if (cnt == CNT_W'(BIN_W - 1)) state <= ST_DONE;
        end
        ST_DONE: begin
          bcd_q  <= result;
          ovf_q  <= ovf_next;
          done_q <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;

endmodule
